// File: rtl/dclk_step_pkg.sv
// Shared types and constants for the dclk step counter.
// Optional stop-on-wrap behaviour is selected with DCLK_STEP_STOP_ON_WRAP_EN.
package dclk_step_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The divider holds dclk high in reset, so a high history means no edge at release.
  localparam logic DCLK_Q_RST = 1'b1;

endpackage

// File: rtl/dclk_rise_detect.sv
// Rising-edge detector for the divided-clock level, sampled in the clk domain.
module dclk_rise_detect
  import dclk_step_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic dclk,
  output logic rise
);

  logic dclk_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dclk_q <= DCLK_Q_RST;
    else        dclk_q <= dclk;
  end

  assign rise = dclk & ~dclk_q;

endmodule

// File: rtl/dclk_step_counter.sv
// Bounded up/down counter stepped once per dclk rising edge under start/stop control.
// Define DCLK_STEP_STOP_ON_WRAP_EN to halt in DONE after a wrap step.
module dclk_step_counter
  import dclk_step_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dclk,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             running
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic             tick_next, wrap_next;
  logic             rise, step, wrap_cond;

  dclk_rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .dclk  (dclk),
    .rise  (rise)
  );

  assign step      = (state == RUN) && rise && !load;
  assign wrap_cond = dir ? (count == MAX_C) : (count == '0);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    tick_next  = 1'b0;
    wrap_next  = 1'b0;

    // stop is tested first in every state so start+stop resolves to IDLE.
    case (state)
      IDLE: if (start && !stop) state_next = RUN;
`ifdef DCLK_STEP_STOP_ON_WRAP_EN
      RUN: begin
        if (stop)                  state_next = IDLE;
        else if (step && wrap_cond) state_next = DONE;
      end
      DONE: begin
        if (load || stop) state_next = IDLE;
        else if (start)   state_next = RUN;
      end
`else
      RUN: if (stop) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase

    if (load) begin
      count_next = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (step) begin
      tick_next = 1'b1;
      if (wrap_cond) begin
        wrap_next  = 1'b1;
        count_next = dir ? '0 : MAX_C;
      end else begin
        count_next = dir ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      tick  <= tick_next;
      wrap  <= wrap_next;
    end
  end

  assign running = (state == RUN);

endmodule
